// File: rtl/fetch_sequencer_if.sv
// Fetch-side bus bundle: instruction-memory request/response plus the decode/retire
// channel between the sequencer and the datapath.
interface fetch_sequencer_if;
  logic        req_valid;
  logic [31:0] req_addr;
  logic        req_ready;
  logic        rsp_valid;
  logic [31:0] rsp_data;
  logic [31:0] Instr;
  logic [31:0] PC;
  logic        InstrValid;
  logic        stall;
  logic [1:0]  PCSrc;
  logic [31:0] ImmExt;
  logic [31:0] ALUResult;

  modport master (
    output req_valid, req_addr, Instr, PC, InstrValid,
    input  req_ready, rsp_valid, rsp_data, stall, PCSrc, ImmExt, ALUResult
  );

  modport slave (
    input  req_valid, req_addr, Instr, PC, InstrValid,
    output req_ready, rsp_valid, rsp_data, stall, PCSrc, ImmExt, ALUResult
  );
endinterface

// File: rtl/fetch_sequencer.sv
// Multi-cycle fetch controller: owns the PC, fetches one word at a time from a
// variable-latency memory, holds it for decode and steers the PC on retire.
module fetch_sequencer #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic               clk,
  input  logic               rst,
  fetch_sequencer_if.master  bus,
  output logic               fault,
  output logic [31:0]        retire_count
);

  typedef enum logic [2:0] {IDLE, REQ, WAIT, EXEC, TRAP} state_t;

  state_t      state_reg, state_next;
  logic [31:0] pc_reg, pc_next;
  logic [31:0] instr_reg, instr_next;
  logic [31:0] count_reg, count_next;
  logic        instr_valid_reg, instr_valid_next;
  logic        fault_reg, fault_next;
  logic [31:0] target;

  // Redirect target; JALR clears bit 0 before the alignment check.
  always_comb begin
    target = pc_reg + 32'd4;
    case (bus.PCSrc)
      2'b01:   target = pc_reg + bus.ImmExt;
      2'b10:   target = bus.ALUResult & ~32'h1;
      default: target = pc_reg + 32'd4;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg       <= IDLE;
      pc_reg          <= RESET_PC;
      instr_reg       <= 32'h0;
      instr_valid_reg <= 1'b0;
      fault_reg       <= 1'b0;
      count_reg       <= 32'h0;
    end else begin
      state_reg       <= state_next;
      pc_reg          <= pc_next;
      instr_reg       <= instr_next;
      instr_valid_reg <= instr_valid_next;
      fault_reg       <= fault_next;
      count_reg       <= count_next;
    end
  end

  always_comb begin
    state_next       = state_reg;
    pc_next          = pc_reg;
    instr_next       = instr_reg;
    instr_valid_next = instr_valid_reg;
    fault_next       = fault_reg;
    count_next       = count_reg;
    case (state_reg)
      IDLE: state_next = REQ;
      REQ: begin
        if (bus.req_ready) state_next = WAIT;
      end
      WAIT: begin
        if (bus.rsp_valid) begin
          instr_next       = bus.rsp_data;
          instr_valid_next = 1'b1;
          state_next       = EXEC;
        end
      end
      EXEC: begin
        if (!bus.stall) begin
          count_next       = count_reg + 32'd1;
          instr_valid_next = 1'b0;
          // A misaligned target retires the instruction but leaves PC on it.
          if (target[1:0] != 2'b00) begin
            fault_next = 1'b1;
            state_next = TRAP;
          end else begin
            pc_next    = target;
            state_next = REQ;
          end
        end
      end
      TRAP:    state_next = TRAP;
      default: state_next = IDLE;
    endcase
  end

  assign bus.req_valid  = (state_reg == REQ);
  assign bus.req_addr   = pc_reg;
  assign bus.Instr      = instr_reg;
  assign bus.PC         = pc_reg;
  assign bus.InstrValid = instr_valid_reg;
  assign fault          = fault_reg;
  assign retire_count   = count_reg;

endmodule

// File: tb/tb_fetch_sequencer.sv
// Self-checking bench for fetch_sequencer: directed vector table, reset/trap
// sequences, then random instructions checked against a PC/retire model.
module tb_fetch_sequencer;

  logic        clk;
  logic        rst;
  logic        fault;
  logic [31:0] retire_count;

  fetch_sequencer_if bus();

  fetch_sequencer #(.RESET_PC(32'h0000_0000)) dut (
    .clk          (clk),
    .rst          (rst),
    .bus          (bus),
    .fault        (fault),
    .retire_count (retire_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int tests_run = 0;
  int tests_failed = 0;

  logic [31:0] m_pc;
  logic [31:0] m_count;

  typedef struct {
    int          rd;
    int          sd;
    int          st;
    logic [1:0]  src;
    logic [31:0] imm;
    logic [31:0] alu;
    logic [31:0] word;
    logic [31:0] exp_pc;
    logic        exp_fault;
  } vec_t;

  vec_t vecs[12];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests_run++;
    if (act !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] ref_target(input logic [31:0] pc, input logic [1:0] src,
                                             input logic [31:0] imm, input logic [31:0] alu);
    if (src == 2'd1) return pc + imm;
    if (src == 2'd2) return {alu[31:1], 1'b0};
    return pc + 32'd4;
  endfunction

  task automatic idle_inputs();
    bus.req_ready = 1'b0;
    bus.rsp_valid = 1'b0;
    bus.rsp_data  = 32'h0;
    bus.stall     = 1'b0;
    bus.PCSrc     = 2'b00;
    bus.ImmExt    = 32'h0;
    bus.ALUResult = 32'h0;
  endtask

  // Called at a falling edge; leaves the DUT one cycle into REQ.
  task automatic do_reset();
    idle_inputs();
    rst = 1'b1;
    #1;
    chk("rst_req_valid", 32'(bus.req_valid), 32'h0);
    chk("rst_instr_valid", 32'(bus.InstrValid), 32'h0);
    chk("rst_fault", 32'(fault), 32'h0);
    chk("rst_retire_count", retire_count, 32'h0);
    chk("rst_pc", bus.PC, 32'h0);
    chk("rst_instr", bus.Instr, 32'h0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("first_req_valid", 32'(bus.req_valid), 32'h1);
    chk("first_req_addr", bus.req_addr, 32'h0);
    m_pc    = 32'h0;
    m_count = 32'h0;
  endtask

  // One full fetch/execute/retire; entered and left at a falling edge in REQ.
  task automatic run_instr(input int rd, input int sd, input int st, input logic [1:0] src,
                           input logic [31:0] imm, input logic [31:0] alu,
                           input logic [31:0] word, input logic [31:0] exp_pc,
                           input logic exp_fault);
    chk("req_valid", 32'(bus.req_valid), 32'h1);
    chk("req_addr", bus.req_addr, m_pc);
    for (int i = 0; i < rd; i++) begin
      bus.rsp_valid = i[0];
      bus.rsp_data  = $urandom;
      @(negedge clk);
      chk("req_hold_valid", 32'(bus.req_valid), 32'h1);
      chk("req_hold_addr", bus.req_addr, m_pc);
      chk("req_no_instr", 32'(bus.InstrValid), 32'h0);
    end
    bus.rsp_valid = 1'b0;
    bus.req_ready = 1'b1;
    @(negedge clk);
    bus.req_ready = 1'b0;
    chk("wait_req_low", 32'(bus.req_valid), 32'h0);
    chk("wait_no_instr", 32'(bus.InstrValid), 32'h0);
    for (int i = 0; i < sd; i++) begin
      @(negedge clk);
      chk("wait_hold", 32'(bus.InstrValid), 32'h0);
    end
    bus.rsp_valid = 1'b1;
    bus.rsp_data  = word;
    bus.stall     = 1'b1;
    @(negedge clk);
    bus.rsp_valid = 1'b0;
    bus.rsp_data  = $urandom;
    chk("exec_valid", 32'(bus.InstrValid), 32'h1);
    chk("exec_instr", bus.Instr, word);
    chk("exec_pc", bus.PC, m_pc);
    for (int i = 0; i < st; i++) begin
      bus.PCSrc     = 2'($urandom);
      bus.ImmExt    = $urandom;
      bus.ALUResult = $urandom;
      @(negedge clk);
      chk("stall_valid", 32'(bus.InstrValid), 32'h1);
      chk("stall_instr", bus.Instr, word);
      chk("stall_pc", bus.PC, m_pc);
      chk("stall_count", retire_count, m_count);
    end
    bus.stall     = 1'b0;
    bus.PCSrc     = src;
    bus.ImmExt    = imm;
    bus.ALUResult = alu;
    @(negedge clk);
    m_count = m_count + 32'd1;
    bus.PCSrc     = 2'($urandom);
    bus.ImmExt    = $urandom;
    bus.ALUResult = $urandom;
    chk("retire_count", retire_count, m_count);
    chk("retire_valid", 32'(bus.InstrValid), 32'h0);
    chk("retire_fault", 32'(fault), 32'(exp_fault));
    chk("retire_pc", bus.PC, exp_pc);
    chk("retire_req", 32'(bus.req_valid), 32'(!exp_fault));
    m_pc = exp_pc;
    $display("[TB] instr pc=%h src=%0d word=%h next=%h fault=%0b count=%0d",
             m_pc, src, word, exp_pc, exp_fault, m_count);
  endtask

  // TRAP must ignore memory traffic and never fetch again.
  task automatic check_trap(input int n);
    for (int i = 0; i < n; i++) begin
      bus.req_ready = 1'b1;
      bus.rsp_valid = i[0];
      bus.rsp_data  = $urandom;
      @(negedge clk);
      chk("trap_req", 32'(bus.req_valid), 32'h0);
      chk("trap_fault", 32'(fault), 32'h1);
      chk("trap_valid", 32'(bus.InstrValid), 32'h0);
      chk("trap_pc", bus.PC, m_pc);
      chk("trap_count", retire_count, m_count);
    end
    idle_inputs();
  endtask

  initial begin
    vecs[0]  = '{0, 0, 0, 2'b00, 32'h0,        32'h0,        32'h00500093, 32'h0000_0004, 1'b0};
    vecs[1]  = '{0, 0, 0, 2'b00, 32'h0,        32'h0,        32'h00100113, 32'h0000_0008, 1'b0};
    vecs[2]  = '{3, 5, 0, 2'b00, 32'h0,        32'h0,        32'h00208193, 32'h0000_000C, 1'b0};
    vecs[3]  = '{1, 2, 1, 2'b00, 32'h0,        32'h0,        32'h00000013, 32'h0000_0010, 1'b0};
    vecs[4]  = '{0, 0, 0, 2'b01, 32'hFFFF_FFF8, 32'h0,       32'hFE000CE3, 32'h0000_0008, 1'b0};
    vecs[5]  = '{0, 1, 0, 2'b10, 32'h0,        32'h0000_0025, 32'h000080E7, 32'h0000_0024, 1'b0};
    vecs[6]  = '{2, 0, 4, 2'b11, 32'h1234_5678, 32'h3,       32'hDEADBEEF, 32'h0000_0028, 1'b0};
    vecs[7]  = '{0, 0, 0, 2'b01, 32'hFFFF_FFD8, 32'h0,       32'h0000006F, 32'h0000_0000, 1'b0};
    vecs[8]  = '{0, 0, 0, 2'b10, 32'h0,        32'hFFFF_FFFD, 32'h00008067, 32'hFFFF_FFFC, 1'b0};
    vecs[9]  = '{0, 0, 0, 2'b00, 32'h0,        32'h0,        32'h00000013, 32'h0000_0000, 1'b0};
    vecs[10] = '{0, 0, 0, 2'b00, 32'h0,        32'h0,        32'h00000013, 32'h0000_0004, 1'b0};
    vecs[11] = '{0, 0, 0, 2'b10, 32'h0,        32'h0000_0102, 32'h000080E7, 32'h0000_0004, 1'b1};

    idle_inputs();
    rst = 1'b1;
    m_pc = 32'h0;
    m_count = 32'h0;
    @(negedge clk);
    do_reset();

    foreach (vecs[i])
      run_instr(vecs[i].rd, vecs[i].sd, vecs[i].st, vecs[i].src, vecs[i].imm,
                vecs[i].alu, vecs[i].word, vecs[i].exp_pc, vecs[i].exp_fault);
    check_trap(8);
    do_reset();

    // Reset while a response is outstanding, with spurious responses afterwards.
    run_instr(0, 0, 0, 2'b00, 32'h0, 32'h0, 32'h11111111, 32'h4, 1'b0);
    bus.req_ready = 1'b1;
    @(negedge clk);
    bus.req_ready = 1'b0;
    rst           = 1'b1;
    bus.rsp_valid = 1'b1;
    bus.rsp_data  = 32'hBAD0_BAD0;
    #1;
    chk("midrst_valid", 32'(bus.InstrValid), 32'h0);
    chk("midrst_req", 32'(bus.req_valid), 32'h0);
    chk("midrst_count", retire_count, 32'h0);
    chk("midrst_pc", bus.PC, 32'h0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("spur_idle_req", 32'(bus.req_valid), 32'h1);
    chk("spur_idle_valid", 32'(bus.InstrValid), 32'h0);
    @(negedge clk);
    chk("spur_req_req", 32'(bus.req_valid), 32'h1);
    chk("spur_req_addr", bus.req_addr, 32'h0);
    chk("spur_req_valid", 32'(bus.InstrValid), 32'h0);
    bus.rsp_valid = 1'b0;
    m_pc    = 32'h0;
    m_count = 32'h0;
    run_instr(0, 0, 0, 2'b00, 32'h0, 32'h0, 32'h22222222, 32'h4, 1'b0);

    // Random instruction stream against the model.
    for (int n = 0; n < 60; n++) begin
      logic [1:0]  src;
      logic [31:0] imm, alu, nxt;
      logic        flt;
      src = 2'($urandom_range(0, 3));
      imm = $urandom;
      alu = $urandom;
      if ($urandom_range(0, 9) < 8) imm[1:0] = 2'b00;
      if ($urandom_range(0, 9) < 7) alu[1] = 1'b0;
      nxt = ref_target(m_pc, src, imm, alu);
      flt = (nxt % 4) != 0;
      run_instr($urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 2), src,
                imm, alu, $urandom, flt ? m_pc : nxt, flt);
      if (flt) begin
        check_trap(3);
        do_reset();
      end
    end

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
